// File: rtl/tsc_pfd_cap.sv
// Time stamp counter with 1pps/1ppms/1ppus strobes, GPS-vs-TSC phase detector
// and edge-triggered timestamp capture channels.
module tsc_pfd_cap #(
   parameter int CLK_HZ = 100_000_000,
   parameter int CNT_W  = 64,
   parameter int N_CAP  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     gps_1pps,
   input  logic                     tsc_sync,
   input  logic                     tsc_read,
   input  logic [N_CAP-1:0]         cap_in,
   input  logic [N_CAP-1:0]         cap_ack,
   output logic [CNT_W-1:0]         tsc_cnt,
   output logic                     tsc_1pps,
   output logic                     tsc_1ppms,
   output logic                     tsc_1ppus,
   output logic signed [31:0]       pdiff,
   output logic                     pdiff_valid,
   output logic                     pdiff_sat,
   output logic [N_CAP*CNT_W-1:0]   cap_ts,
   output logic [N_CAP-1:0]         cap_valid,
   output logic [N_CAP-1:0]         cap_ovf
);

   localparam int MS_DIV = CLK_HZ / 1000;
   localparam int US_DIV = CLK_HZ / 1_000_000;
   localparam int HALF   = CLK_HZ / 2;
   localparam int PPS_W  = $clog2(CLK_HZ);
   localparam int MS_W   = $clog2(MS_DIV);
   localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;

   generate
      if (CLK_HZ % 1_000_000 != 0) begin : g_badClk
         $error("tsc_pfd_cap: CLK_HZ must be a multiple of 1_000_000");
      end
      if (N_CAP < 1 || N_CAP > 16) begin : g_badCap
         $error("tsc_pfd_cap: N_CAP must be in 1..16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, G_FIRST, T_FIRST} phState_t;

   logic [CNT_W-1:0]              r_cnt;
   logic [CNT_W-1:0]              r_tscSnap;
   logic [2:0]                    r_gpsDly;
   logic                          r_gpsPulse;
   logic                          r_ppsRst;
   logic [PPS_W-1:0]              r_ppsCnt;
   logic [MS_W-1:0]               r_msCnt;
   logic [US_W-1:0]               r_usCnt;
   logic                          r_pps;
   logic                          r_ms;
   logic                          r_us;
   logic [2:0]                    r_tscDly;
   phState_t                      r_state;
   phState_t                      w_stateNxt;
   logic [31:0]                   r_phCnt;
   logic [31:0]                   w_phCntNxt;
   logic signed [31:0]            r_pdiff;
   logic signed [31:0]            w_pdiffNxt;
   logic                          r_valid;
   logic                          w_validNxt;
   logic                          r_sat;
   logic                          w_satNxt;
   logic [N_CAP-1:0]              r_capS0;
   logic [N_CAP-1:0]              r_capS1;
   logic [N_CAP-1:0]              r_capS2;
   logic [N_CAP-1:0]              r_capEdge;
   logic [N_CAP-1:0][CNT_W-1:0]   r_capTs;
   logic [N_CAP-1:0]              r_capValid;
   logic [N_CAP-1:0]              r_capOvf;

   logic                          w_ppsWrap;
   logic                          w_msWrap;
   logic                          w_usWrap;
   logic                          w_ppsTerm;
   logic                          w_msTerm;
   logic                          w_usTerm;
   logic                          w_tscPulse;
   logic [CNT_W-1:0]              w_stamp;

   assign w_ppsWrap  = (r_ppsCnt == PPS_W'(CLK_HZ - 1));
   assign w_msWrap   = (r_msCnt == MS_W'(MS_DIV - 1));
   assign w_usWrap   = (r_usCnt == US_W'(US_DIV - 1));
   assign w_ppsTerm  = (r_ppsCnt == PPS_W'(CLK_HZ - 2));
   assign w_msTerm   = (r_msCnt == MS_W'(MS_DIV - 2));
   assign w_usTerm   = (US_DIV == 1) ? 1'b1 : (r_usCnt == US_W'(US_DIV - 2));
   assign w_tscPulse = r_tscDly[2];
   assign w_stamp    = r_cnt - CNT_W'(3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_tscSnap <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (tsc_read) begin
            r_tscSnap <= r_cnt;
         end
      end
   end

   // GPS edge detect; a pulse with tsc_sync high becomes the divider realign
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gpsDly   <= '0;
         r_gpsPulse <= 1'b0;
         r_ppsRst   <= 1'b0;
      end else begin
         r_gpsDly   <= {r_gpsDly[1:0], gps_1pps};
         r_gpsPulse <= r_gpsDly[1] & ~r_gpsDly[2];
         r_ppsRst   <= tsc_sync & r_gpsPulse;
      end
   end

   // Terminal counts are registered one count early so each strobe lands on the wrap cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ppsCnt <= '0;
         r_msCnt  <= '0;
         r_usCnt  <= '0;
         r_pps    <= 1'b0;
         r_ms     <= 1'b0;
         r_us     <= 1'b0;
         r_tscDly <= '0;
      end else if (r_ppsRst) begin
         r_ppsCnt <= '0;
         r_msCnt  <= '0;
         r_usCnt  <= '0;
         r_pps    <= 1'b0;
         r_ms     <= 1'b0;
         r_us     <= 1'b0;
         r_tscDly <= '0;
      end else begin
         r_ppsCnt <= w_ppsWrap ? '0 : r_ppsCnt + PPS_W'(1);
         r_msCnt  <= (w_ppsWrap || w_msWrap) ? '0 : r_msCnt + MS_W'(1);
         r_usCnt  <= (w_ppsWrap || w_usWrap) ? '0 : r_usCnt + US_W'(1);
         r_pps    <= w_ppsTerm;
         r_ms     <= w_msTerm;
         r_us     <= w_usTerm;
         r_tscDly <= {r_tscDly[1:0], r_pps};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_phCnt <= '0;
         r_pdiff <= '0;
         r_valid <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_stateNxt;
         r_phCnt <= w_phCntNxt;
         r_pdiff <= w_pdiffNxt;
         r_valid <= w_validNxt;
         r_sat   <= w_satNxt;
      end
   end

   // The closing edge wins over a simultaneous new opposite edge, which is dropped
   always_comb begin
      w_stateNxt = r_state;
      w_phCntNxt = r_phCnt;
      w_pdiffNxt = r_pdiff;
      w_validNxt = 1'b0;
      w_satNxt   = r_sat;
      if (r_ppsRst) begin
         w_stateNxt = IDLE;
         w_phCntNxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_gpsPulse && w_tscPulse) begin
                  w_pdiffNxt = '0;
                  w_validNxt = 1'b1;
                  w_satNxt   = 1'b0;
               end else if (r_gpsPulse) begin
                  w_stateNxt = G_FIRST;
                  w_phCntNxt = 32'd1;
               end else if (w_tscPulse) begin
                  w_stateNxt = T_FIRST;
                  w_phCntNxt = 32'd1;
               end
            end
            G_FIRST: begin
               if (w_tscPulse) begin
                  w_pdiffNxt = $signed(r_phCnt);
                  w_validNxt = 1'b1;
                  w_satNxt   = 1'b0;
                  w_stateNxt = IDLE;
               end else if (r_phCnt == 32'(HALF)) begin
                  w_pdiffNxt = 32'(HALF);
                  w_validNxt = 1'b1;
                  w_satNxt   = 1'b1;
                  w_stateNxt = IDLE;
               end else begin
                  w_phCntNxt = r_phCnt + 32'd1;
               end
            end
            T_FIRST: begin
               if (r_gpsPulse) begin
                  w_pdiffNxt = -$signed(r_phCnt);
                  w_validNxt = 1'b1;
                  w_satNxt   = 1'b0;
                  w_stateNxt = IDLE;
               end else if (r_phCnt == 32'(HALF)) begin
                  w_pdiffNxt = -32'(HALF);
                  w_validNxt = 1'b1;
                  w_satNxt   = 1'b1;
                  w_stateNxt = IDLE;
               end else begin
                  w_phCntNxt = r_phCnt + 32'd1;
               end
            end
            default: begin
               w_stateNxt = IDLE;
            end
         endcase
      end
   end

   // Capture stamp subtracts the 3-cycle sync/edge latency to date the input rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_capS0    <= '0;
         r_capS1    <= '0;
         r_capS2    <= '0;
         r_capEdge  <= '0;
         r_capTs    <= '0;
         r_capValid <= '0;
         r_capOvf   <= '0;
      end else begin
         r_capS0   <= cap_in;
         r_capS1   <= r_capS0;
         r_capS2   <= r_capS1;
         r_capEdge <= r_capS1 & ~r_capS2;
         for (int i = 0; i < N_CAP; i++) begin
            if (r_capEdge[i]) begin
               if (!r_capValid[i] || cap_ack[i]) begin
                  r_capTs[i]    <= w_stamp;
                  r_capValid[i] <= 1'b1;
                  r_capOvf[i]   <= 1'b0;
               end else begin
                  r_capOvf[i] <= 1'b1;
               end
            end else if (cap_ack[i]) begin
               r_capValid[i] <= 1'b0;
               r_capOvf[i]   <= 1'b0;
            end
         end
      end
   end

   assign tsc_cnt     = r_tscSnap;
   assign tsc_1pps    = r_pps;
   assign tsc_1ppms   = r_ms;
   assign tsc_1ppus   = r_us;
   assign pdiff       = r_pdiff;
   assign pdiff_valid = r_valid;
   assign pdiff_sat   = r_sat;
   assign cap_ts      = r_capTs;
   assign cap_valid   = r_capValid;
   assign cap_ovf     = r_capOvf;

endmodule
